instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Instruction fetch stage with a small prefetch queue. It feeds the decode stage of the 5-stage MIPS pipeline.
- Drives the instruction memory address and captures its synchronous read data into a FIFO of {pc, instr} pairs.
- Presents the FIFO head to decode through a valid/ready handshake, so decode stalls never lose an instruction.
- Accepts a redirect (branch/jump target) from execute; a redirect flushes all queued and in-flight fetches.

Parameters:
- PC_W, 10: PC width; also the instruction memory address width.
- PC_STEP, 4: PC increment per fetched instruction. The PC is used directly as the memory address.
- RESET_PC, 0: PC value loaded on reset.
- DEPTH, 4: queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  out  PC_W  instruction memory address; always equals the internal pc register.
- imem_q  in  32  instruction memory read data; valid one cycle after imem_addr is sampled.
- if_valid  out  1  queue head holds a valid instruction.
- if_instr  out  32  head instruction.
- if_pc  out  PC_W  address the head instruction was fetched from.
- if_ready  in  1  decode accepts the head this cycle.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  PC_W  new fetch address.

Behaviour:
- Clocking: one clock domain; reset is synchronous and active-high, on ports clk and rst.
- State machine: WAIT, FETCH.
  - rst=1 gives pc=RESET_PC, count=0, pend=0, rd_ptr=wr_ptr=0, state=WAIT.
  - Output reset values: if_valid=0, if_instr=0, if_pc=0, imem_addr=RESET_PC.
  - WAIT → FETCH unconditionally on the next edge with rst=0. This one idle cycle matches the pipeline's post-reset halt cycle.
- Issue rule:
  - issue = (state==FETCH) && !redirect_valid && (count + pend < DEPTH).
  - On issue: pend<=1, pend_pc<=pc, pc<=pc+PC_STEP.
  - Otherwise pend<=0 and pc holds. The memory re-reads the same address, which is harmless.
- Capture: if pend=1 at an edge and no redirect, write {pend_pc, imem_q} at wr_ptr, then wr_ptr++ and count++.
- Pop: if if_valid && if_ready && !redirect_valid, then rd_ptr++ and count--.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Outputs:
  - if_valid = (count != 0).
  - if_instr and if_pc come from entry[rd_ptr] and are held stable while if_valid && !if_ready.
  - When count=0 they show the stale entry; consumers ignore them.
- Full: the reservation rule (count + pend < DEPTH) guarantees a capture never overflows. Reaching count=DEPTH stops issue until a pop.
- Empty: if_valid=0; a pop request is ignored.
- Redirect, in any FETCH cycle with redirect_valid=1:
  - count<=0, pointers<=0, pend<=0 (the read returning next cycle is discarded), pc<=redirect_pc.
  - Redirect has priority over issue, capture and pop.
  - Issue resumes the following cycle.
  - Redirect in WAIT only loads pc<=redirect_pc.
- Reset has priority over redirect. Reset mid-operation discards everything immediately.
- Latency:
  - First if_valid=1 after the 3rd rising edge with rst=0.
  - After a redirect edge, the target's instruction is valid after 2 more edges.
  - Steady state: 1 instruction/cycle when if_ready=1.
- Arithmetic: pc wraps modulo 2^PC_W. count width is clog2(DEPTH)+1.

Optional Feature:
- Macro IFQ_PERF_EN.
- When defined, adds two outputs:
  - perf_issue_cnt, 32 bits: +1 per issue.
  - perf_flush_cnt, 16 bits: +1 per redirect accepted in FETCH.
- Both counters are cleared by rst and wrap on overflow. Counter width is fixed regardless of PC_W.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then if_ready=1, memory word at addr k = 0x1000_0000+k → if_valid rises after the 3rd edge. Sequence (if_pc, if_instr) = (0,0x10000000), (4,0x10000004), (8,0x10000008), one per cycle.
- if_ready=0 for 10 cycles after the first valid → count saturates at 4 with no overflow. if_pc holds at 0. On release the outputs are pc 0, 4, 8, 12, 16 with no gaps or duplicates.
- redirect_valid=1, redirect_pc=0x040 while 3 entries are queued → if_valid=0 the next cycle. The next valid if_pc=0x040; no pre-redirect address ever appears.
- Redirect asserted in the cycle right after an issue to 0x00C → the 0x00C data is discarded and never presented.
- rst=1 pulsed mid-stream with a full queue → if_valid=0 and imem_addr=0 next cycle. Restart timing matches the first test.
- With IFQ_PERF_EN: 20 fetches and 2 redirects → perf_issue_cnt equals the observed issue count and perf_flush_cnt=2. Both read 0 after rst.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage with a prefetch queue of {pc, instr} pairs feeding decode.
// Define IFQ_PERF_EN to add the perf_issue_cnt / perf_flush_cnt counters.
module instr_fetch_queue #(
    parameter int          PC_W     = 10,
    parameter int          PC_STEP  = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int          DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_q,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    input  logic            if_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]     perf_issue_cnt,
    output logic [15:0]     perf_flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    localparam logic [0:0] ST_WAIT  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      instr_d [DEPTH];
    logic [PC_W-1:0]  entry_pc_q [DEPTH];
    logic [PC_W-1:0]  entry_pc_d [DEPTH];

    logic             in_fetch;
    logic             flush;
    logic             issue;
    logic             capture;
    logic             pop;
    logic [CNT_W:0]   occupancy;

    // The pending read reserves a slot, so a capture can never find the queue full.
    always_comb begin
        in_fetch  = (state_q == ST_FETCH);
        flush     = in_fetch && redirect_valid;
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
        issue     = in_fetch && !redirect_valid && (occupancy < DEPTH_C);
        capture   = pend_q && !redirect_valid;
        pop       = (count_q != '0) && if_ready && !redirect_valid;
    end

    always_comb begin
        state_d    = ST_FETCH;
        pc_d       = pc_q;
        pend_d     = 1'b0;
        pend_pc_d  = pend_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        instr_d    = instr_q;
        entry_pc_d = entry_pc_q;

        if (flush) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (!in_fetch) begin
            if (redirect_valid) begin
                pc_d = redirect_pc;
            end
        end else begin
            pend_d = issue;
            if (issue) begin
                pend_pc_d = pc_q;
                pc_d      = pc_q + PC_W'(PC_STEP);
            end
            if (capture) begin
                instr_d[wr_ptr_q]    = imem_q;
                entry_pc_d[wr_ptr_q] = pend_pc_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(capture) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            pc_q      <= PC_W'(RESET_PC);
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i]    <= '0;
                entry_pc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            entry_pc_q <= entry_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = (count_q != '0);
    assign if_instr  = instr_q[rd_ptr_q];
    assign if_pc     = entry_pc_q[rd_ptr_q];

`ifdef IFQ_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_issue_d = perf_issue_q + 32'(issue);
        perf_flush_d = perf_flush_q + 16'(flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int PC_W  = 10;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_q;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            if_ready = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
`ifdef IFQ_PERF_EN
    logic [31:0]     perf_issue_cnt;
    logic [15:0]     perf_flush_cnt;
`endif

    instr_fetch_queue #(.PC_W(PC_W), .PC_STEP(4), .RESET_PC(0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFQ_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears one cycle after the address.
    logic [31:0] memimg [1024];
    always @(posedge clk) imem_q <= memimg[imem_addr];

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } ent_t;

    ent_t            m_q[$];
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_pend_pc;
    bit              m_pend;
    bit              m_fetch;
    logic [31:0]     m_issue;
    logic [15:0]     m_flush;
    logic [PC_W-1:0] accepted[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit do_issue;
        if (rst) begin
            m_pc    = '0;
            m_q.delete();
            m_pend  = 0;
            m_fetch = 0;
            m_issue = '0;
            m_flush = '0;
        end else if (!m_fetch) begin
            m_fetch = 1;
            if (redirect_valid) m_pc = redirect_pc;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pend = 0;
            m_pc   = redirect_pc;
            m_flush++;
        end else begin
            do_issue = (m_q.size() + int'(m_pend)) < DEPTH;
            if (m_q.size() > 0 && if_ready) void'(m_q.pop_front());
            if (m_pend) m_q.push_back('{m_pend_pc, memimg[m_pend_pc]});
            m_pend = do_issue;
            if (do_issue) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 10'd4;
                m_issue++;
            end
        end
    endtask

    task automatic compare_model();
        check("model_valid", if_valid, (m_q.size() != 0));
        check("model_addr", imem_addr, m_pc);
        if (m_q.size() != 0) begin
            check("model_pc", if_pc, m_q[0].pc);
            check("model_instr", if_instr, m_q[0].instr);
        end
`ifdef IFQ_PERF_EN
        check("perf_issue", perf_issue_cnt, m_issue);
        check("perf_flush", perf_flush_cnt, m_flush);
`endif
    endtask

    // One clock: record the handshake about to happen, advance the model, compare after the edge.
    task automatic step();
        if (!rst && !redirect_valid && if_valid && if_ready) accepted.push_back(if_pc);
        model_update();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic apply_stimulus(input logic r, input logic rv, input logic [PC_W-1:0] rpc,
                                  input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        step();
    endtask

    typedef struct {
        logic            rst;
        logic            rv;
        logic [PC_W-1:0] rpc;
        logic            rdy;
        logic            exp_valid;
        logic [PC_W-1:0] exp_addr;
        logic [PC_W-1:0] exp_pc;
        logic [31:0]     exp_instr;
        logic            chk_data;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit ok;
        int waited;

        for (int k = 0; k < 1024; k++) memimg[k] = 32'h1000_0000 + k;

        vecs[0]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h000, 32'h0,         1'b1};
        vecs[1]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h000, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h004, 10'h000, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h008, 10'h000, 32'h1000_0000, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h00C, 10'h004, 32'h1000_0004, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 10'h008, 32'h1000_0008, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h014, 10'h008, 32'h1000_0008, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 10'h040, 1'b1, 1'b0, 10'h040, 10'h000, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h044, 10'h000, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h048, 10'h040, 32'h1000_0040, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h000, 32'h0,         1'b1};

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), if_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_instr);
            end
        end

        // Decode stall right after the first instruction: queue fills, head holds, nothing lost.
        apply_stimulus(1'b1, 1'b0, '0, 1'b1);
        waited = 0;
        rst = 1'b0;
        while (!if_valid && waited < 10) begin step(); waited++; end
        check("stall_first_valid_seen", if_valid, 1'b1);
        if_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_hold_pc", if_pc, 10'h000);
        end
        check("stall_full_valid", if_valid, 1'b1);
        accepted.delete();
        if_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("stall_accept_count_ge5", (accepted.size() >= 5), 1'b1);
        for (int i = 0; i < 5 && i < accepted.size(); i++)
            check($sformatf("stall_release_pc%0d", i), accepted[i], 32'(i * 4));

        // Redirect while three entries are queued.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0);
        rst = 1'b0;
        waited = 0;
        while (m_q.size() != 3 && waited < 20) begin step(); waited++; end
        check("redir_three_queued", if_valid, 1'b1);
        accepted.delete();
        apply_stimulus(1'b0, 1'b1, 10'h040, 1'b1);
        check("redir_flush_valid", if_valid, 1'b0);
        redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("redir_accept_nonempty", (accepted.size() > 0), 1'b1);
        if (accepted.size() > 0) check("redir_first_pc", accepted[0], 10'h040);
        ok = 1;
        foreach (accepted[i]) if (accepted[i] < 10'h040) ok = 0;
        check("redir_no_stale_pc", ok, 1'b1);

        // Redirect in the cycle right after 0x00C was issued: its data must never surface.
        apply_stimulus(1'b1, 1'b0, '0, 1'b1);
        rst = 1'b0;
        waited = 0;
        while (imem_addr != 10'h010 && waited < 20) begin step(); waited++; end
        check("late_redir_reach_0x10", imem_addr, 10'h010);
        accepted.delete();
        apply_stimulus(1'b0, 1'b1, 10'h100, 1'b1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        ok = 1;
        foreach (accepted[i]) if (accepted[i] == 10'h00C) ok = 0;
        check("late_redir_no_0x0c", ok, 1'b1);
        if (accepted.size() > 0) check("late_redir_first_pc", accepted[0], 10'h100);
        else check("late_redir_accept_nonempty", 1'b0, 1'b1);

        // Reset with a full queue, then the same start-up timing as from power-on.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0);
        rst = 1'b0;
        waited = 0;
        while (m_q.size() != DEPTH && waited < 20) begin step(); waited++; end
        check("rst_full_valid", if_valid, 1'b1);
        apply_stimulus(1'b1, 1'b0, '0, 1'b1);
        check("rst_mid_valid", if_valid, 1'b0);
        check("rst_mid_addr", imem_addr, 10'h000);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        check("restart_edge1_valid", if_valid, 1'b0);
        step();
        check("restart_edge2_valid", if_valid, 1'b0);
        step();
        check("restart_edge3_valid", if_valid, 1'b1);
        check("restart_edge3_pc", if_pc, 10'h000);

        // Randomized traffic with random memory contents and pc wrap-around.
        for (int k = 0; k < 1024; k++) memimg[k] = $urandom;
        apply_stimulus(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom_range(0, 199) == 0),
                           ($urandom_range(0, 19) == 0),
                           10'($urandom_range(0, 1023)),
                           ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
